// File: rtl/dff_bank_rr_writer.sv
// rtl/dff_bank_rr_writer.sv - round-robin arbiter and write sequencer for one shared register
//
// Grants one of NREQ requesters at a time, loads its data word into the shared
// WIDTH-bit register q and returns a one-cycle one-hot acknowledge.
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous, active-high reset
//   req      per-requester write request, held until the matching ack is sampled
//   wdata    requester i data word is wdata[i*WIDTH +: WIDTH]
//   ack      one-hot, one-cycle pulse once requester i's data is in q
//   gnt_id   index of the current/last granted requester
//   busy     high while a write is in flight (WRITE or DONE)
//   q        shared register contents
//   q_valid  high once any write has completed since reset

module dff_bank_rr_writer #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       ack,
    output logic [IDW-1:0]        gnt_id,
    output logic                  busy,
    output logic [WIDTH-1:0]      q,
    output logic                  q_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] winner;
    int             idx;

    // Rotating priority search starting at ptr. The loop runs from the farthest
    // offset down to offset 0 so the nearest requesting index is assigned last.
    always_comb begin
        winner = ptr;
        idx    = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (req[idx]) begin
                winner = IDW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // DONE is a mandatory gap so a requester that drops req on seeing ack is
    // not re-arbitrated on stale req.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (|req) state_next = WRITE;
            WRITE:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q       <= '0;
            q_valid <= 1'b0;
            ack     <= '0;
            gnt_id  <= '0;
            ptr     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt_id <= winner;
                    end
                end
                WRITE: begin
                    // Committed write: req[gnt_id] is not re-checked here.
                    q       <= wdata[int'(gnt_id) * WIDTH +: WIDTH];
                    q_valid <= 1'b1;
                    ack     <= NREQ'(1) << gnt_id;
                    ptr     <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
                end
                DONE: begin
                    ack <= '0;
                end
                default: begin
                    ack <= '0;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_dff_bank_rr_writer.sv
// tb/tb_dff_bank_rr_writer.sv - self-checking bench for dff_bank_rr_writer

module tb_dff_bank_rr_writer;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = 2;

    logic                  clk;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       ack;
    logic [IDW-1:0]        gnt_id;
    logic                  busy;
    logic [WIDTH-1:0]      q;
    logic                  q_valid;

    dff_bank_rr_writer #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .wdata   (wdata),
        .ack     (ack),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .q       (q),
        .q_valid (q_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: requester data words, request vector, next-priority index.
    logic [WIDTH-1:0] data_m [NREQ];
    logic [NREQ-1:0]  req_v;
    int               ptr_m;
    int               last_w;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive();
        req = req_v;
        for (int i = 0; i < NREQ; i++) wdata[i*WIDTH +: WIDTH] = data_m[i];
    endtask

    // First requester at or after ptr, wrapping around.
    function automatic int pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        req_v = '0;
        drive();
        step();
        step();
        reset = 1'b0;
        ptr_m = 0;
        chk("rst_q", 32'(q), 32'h0);
        chk("rst_q_valid", 32'(q_valid), 32'h0);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_gnt_id", 32'(gnt_id), 32'h0);
    endtask

    // One full arbitration/write/done round starting in IDLE with req_v nonzero.
    task automatic transact(input bit drop_acked);
        int w;
        logic [WIDTH-1:0] d;
        w = pick(req_v, ptr_m);
        d = data_m[w];
        step();
        chk("e0_gnt_id", 32'(gnt_id), 32'(w));
        chk("e0_busy", 32'(busy), 32'h1);
        chk("e0_ack", 32'(ack), 32'h0);
        step();
        chk("e1_q", 32'(q), 32'(d));
        chk("e1_ack", 32'(ack), 32'(1 << w));
        chk("e1_q_valid", 32'(q_valid), 32'h1);
        step();
        chk("e2_ack", 32'(ack), 32'h0);
        chk("e2_busy", 32'(busy), 32'h0);
        chk("e2_q", 32'(q), 32'(d));
        ptr_m  = (w + 1) % NREQ;
        last_w = w;
        if (drop_acked) begin
            req_v[w] = 1'b0;
            drive();
        end
    endtask

    initial begin
        int exp_seq [5];
        reset  = 1'b1;
        req    = '0;
        wdata  = '0;
        req_v  = '0;
        ptr_m  = 0;
        last_w = 0;
        for (int i = 0; i < NREQ; i++) data_m[i] = '0;

        // 1: reset state
        do_reset();

        // 2: single requester 2
        data_m[2] = 8'hA5;
        req_v     = 4'b0100;
        drive();
        transact(1'b1);
        chk("t2_gnt", 32'(last_w), 32'h2);

        // 3: all requesting, rotation 0,1,2,3,0
        do_reset();
        for (int i = 0; i < NREQ; i++) data_m[i] = WIDTH'(8'h10 + i);
        req_v = 4'b1111;
        drive();
        exp_seq = '{0, 1, 2, 3, 0};
        for (int n = 0; n < 5; n++) begin
            transact(1'b0);
            chk("t3_order", 32'(last_w), 32'(exp_seq[n]));
        end

        // 4: grant to 3 wraps ptr, then 1,3,1 from req=1010
        req_v = 4'b1000;
        drive();
        transact(1'b1);
        chk("t4_first", 32'(last_w), 32'h3);
        req_v = 4'b1010;
        drive();
        transact(1'b0);
        chk("t4_a", 32'(last_w), 32'h1);
        transact(1'b0);
        chk("t4_b", 32'(last_w), 32'h3);
        transact(1'b0);
        chk("t4_c", 32'(last_w), 32'h1);

        // 5: req[1] dropped while in WRITE; write still completes, no regrant
        req_v     = 4'b0010;
        data_m[1] = 8'h5E;
        drive();
        step();
        chk("t5_gnt", 32'(gnt_id), 32'h1);
        req_v = '0;
        drive();
        step();
        chk("t5_ack", 32'(ack), 32'h2);
        chk("t5_q", 32'(q), 32'h5E);
        step();
        chk("t5_ack_off", 32'(ack), 32'h0);
        for (int n = 0; n < 4; n++) begin
            step();
            chk("t5_no_regrant_busy", 32'(busy), 32'h0);
            chk("t5_no_regrant_ack", 32'(ack), 32'h0);
        end
        ptr_m = 2;

        // 6: reset sampled at the WRITE edge abandons the write
        do_reset();
        data_m[2] = 8'h3C;
        req_v     = 4'b0100;
        drive();
        step();
        chk("t6_gnt", 32'(gnt_id), 32'h2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        ptr_m = 0;
        chk("t6_q", 32'(q), 32'h0);
        chk("t6_ack", 32'(ack), 32'h0);
        chk("t6_busy", 32'(busy), 32'h0);
        chk("t6_q_valid", 32'(q_valid), 32'h0);
        transact(1'b1);
        chk("t6_regrant", 32'(last_w), 32'h2);

        // Random: pending requesters hold req and data; the acked one and idle
        // ones may change.
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_v[i] || i == last_w) begin
                    req_v[i]  = 1'($urandom_range(0, 1));
                    data_m[i] = WIDTH'($urandom);
                end
            end
            if (req_v == '0) req_v[$urandom_range(0, NREQ - 1)] = 1'b1;
            drive();
            transact(1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
